// File: rtl/basys3_seg_scan.sv
// basys3_seg_scan: time-multiplexed driver for the Basys3 4-digit 7-segment
// display. Shows a 16-bit value as four hex digits with per-digit decimal point
// and blanking. All pins are active low. New data is staged in a shadow register
// and copied to the display registers only at a frame boundary, so a frame never
// shows a mix of old and new digits.
module basys3_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Hex digit to segment pattern, g..a, active low.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      shadow_value_r;
  logic [3:0]       shadow_dp_r;
  logic [3:0]       shadow_blank_r;
  logic [15:0]      disp_value_r;
  logic [3:0]       disp_dp_r;
  logic [3:0]       disp_blank_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_r;
  logic             frame_r;

  logic             wrap_s;
  logic             frame_edge_s;
  logic             in_blank_s;
  logic [3:0]       digit_s;
  logic [6:0]       seg_s;
  logic             dp_s;
  logic [3:0]       an_s;

  assign wrap_s       = (cnt_r == CNT_LAST);
  assign frame_edge_s = wrap_s && (idx_r == 2'd3);

  // With no blank window the comparison would be constant; elaborate it away.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_s = 1'b0;
    end else begin : g_blank
      assign in_blank_s = (cnt_r < BLANK_END);
    end
  endgenerate

  // Slot counter and digit index: cnt sweeps one slot, idx steps each wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (wrap_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Shadow register: the last load before a frame boundary wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_value_r <= 16'h0000;
      shadow_dp_r    <= 4'h0;
      shadow_blank_r <= 4'hF;
    end else if (load) begin
      shadow_value_r <= value;
      shadow_dp_r    <= dp_in;
      shadow_blank_r <= blank_in;
    end else begin
      shadow_value_r <= shadow_value_r;
      shadow_dp_r    <= shadow_dp_r;
      shadow_blank_r <= shadow_blank_r;
    end
  end

  // Display registers take the pre-edge shadow only at the frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_value_r <= 16'h0000;
      disp_dp_r    <= 4'h0;
      disp_blank_r <= 4'hF;
    end else if (frame_edge_s) begin
      disp_value_r <= shadow_value_r;
      disp_dp_r    <= shadow_dp_r;
      disp_blank_r <= shadow_blank_r;
    end else begin
      disp_value_r <= disp_value_r;
      disp_dp_r    <= disp_dp_r;
      disp_blank_r <= disp_blank_r;
    end
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    digit_s = 4'h0;
    case (idx_r)
      2'd0:    digit_s = disp_value_r[3:0];
      2'd1:    digit_s = disp_value_r[7:4];
      2'd2:    digit_s = disp_value_r[11:8];
      2'd3:    digit_s = disp_value_r[15:12];
      default: digit_s = 4'h0;
    endcase
  end

  // Next pin values: dark during the anti-ghost window or for a blanked digit.
  always_comb begin
    an_s  = 4'hF;
    seg_s = 7'h7F;
    dp_s  = 1'b1;
    if (in_blank_s || disp_blank_r[idx_r]) begin
      an_s  = 4'hF;
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end else begin
      an_s  = ~(4'b0001 << idx_r);
      seg_s = hex7(digit_s);
      dp_s  = ~disp_dp_r[idx_r];
    end
  end

  // Output registers: pins lag the scan state by one cycle, glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_r   <= 7'h7F;
      dp_r    <= 1'b1;
      an_r    <= 4'hF;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_s;
      dp_r    <= dp_s;
      an_r    <= an_s;
      frame_r <= frame_edge_s;
    end
  end

  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_basys3_seg_scan.sv
// Bench for basys3_seg_scan: two instances (blank window 2 and 0) share random
// and directed stimulus; expected pins come from a cycle-count reference model.
module tb_basys3_seg_scan;

  localparam int DIV   = 8;
  localparam int FRAME = 4 * DIV;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        frame_a, frame_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  basys3_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .seg(seg_a), .dp(dp_a), .an(an_a),
    .frame(frame_a)
  );

  basys3_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .seg(seg_b), .dp(dp_b), .an(an_b),
    .frame(frame_b)
  );

  // Reference model state: cycles since reset plus shadow/display contents.
  int          t;
  logic [15:0] sh_v, ds_v;
  logic [3:0]  sh_dp, sh_bl, ds_dp, ds_bl;
  logic [6:0]  hex_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected {an,dp,seg} for scan position t with a given blank window.
  function automatic logic [11:0] pins(input int tt, input int bc);
    int pos, d;
    logic [3:0] nib;
    pos = tt % DIV;
    d   = (tt / DIV) % 4;
    if (pos < bc || ds_bl[d]) return {4'hF, 1'b1, 7'h7F};
    nib = ds_v[4*d +: 4];
    return {4'hF & ~(4'd1 << d), ~ds_dp[d], hex_tab[nib]};
  endfunction

  task automatic tick();
    logic [11:0] ea, eb;
    logic        ef;
    if (reset) begin
      ea = {4'hF, 1'b1, 7'h7F};
      eb = ea;
      ef = 1'b0;
    end else begin
      ea = pins(t, 2);
      eb = pins(t, 0);
      ef = (t % FRAME) == FRAME - 1;
    end
    @(posedge clock);
    if (reset) begin
      t = 0;
      sh_v = 16'h0; sh_dp = 4'h0; sh_bl = 4'hF;
      ds_v = 16'h0; ds_dp = 4'h0; ds_bl = 4'hF;
    end else begin
      if ((t % FRAME) == FRAME - 1) begin
        ds_v = sh_v; ds_dp = sh_dp; ds_bl = sh_bl;
      end
      if (load) begin
        sh_v = value; sh_dp = dp_in; sh_bl = blank_in;
      end
      t++;
    end
    #1;
    check("pins_b2", {20'h0, an_a, dp_a, seg_a}, {20'h0, ea});
    check("pins_b0", {20'h0, an_b, dp_b, seg_b}, {20'h0, eb});
    check("frame_b2", {31'h0, frame_a}, {31'h0, ef});
    check("frame_b0", {31'h0, frame_b}, {31'h0, ef});
    check("one_anode", {31'h0, ($countones(~an_a) <= 1) && ($countones(~an_b) <= 1)}, 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the model reaches a given position inside the frame.
  task automatic seek(input int pos);
    int k;
    k = 0;
    while ((t % FRAME) != pos && k < 2 * FRAME) begin
      tick();
      k++;
    end
    check("seek_bound", {31'h0, (t % FRAME) == pos}, 32'd1);
  endtask

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100;
    hex_tab[3]  = 7'b0110000; hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000; hex_tab[8]  = 7'b0000000;
    hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110;
    hex_tab[15] = 7'b0001110;
    t = 0;
    sh_v = 16'h0; sh_dp = 4'h0; sh_bl = 4'hF;
    ds_v = 16'h0; ds_dp = 4'h0; ds_bl = 4'hF;
    value = 16'h0; dp_in = 4'h0; blank_in = 4'h0; load = 1'b0;

    // Reset, then idle: display stays dark, frame pulses every 32 cycles.
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2 * FRAME);

    // Directed value 1A80 with all digits enabled.
    do_load(16'h1A80, 4'h0, 4'h0);
    run(FRAME + FRAME + 8);

    // Load coincident with the frame edge: shown one frame later.
    seek(FRAME - 1);
    do_load(16'h3C5E, 4'h6, 4'h0);
    run(2 * FRAME + 4);

    // Blanking and decimal points.
    do_load(16'hFFFF, 4'b0001, 4'b1010);
    run(2 * FRAME);

    // Random loads, including repeated loads within a frame.
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(10, 70);
      for (int c = 0; c < len; c++) begin
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        blank_in = 4'($urandom);
        load     = ($urandom_range(0, 5) == 0);
        tick();
      end
      load = 1'b0;
      run($urandom_range(0, 40));
    end

    // Reset mid-DRIVE of digit 2 with a pending load.
    do_load(16'h2468, 4'hF, 4'h0);
    run(FRAME);
    seek(2 * DIV + 4);
    value = 16'h9999; load = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; load = 1'b0;
    run(FRAME + 8);
    do_load(16'hBEEF, 4'h5, 4'h0);
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
